// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin bus arbiter with bus lock and per-grant ack timeout.
// Slave-side signals are a combinational mux of the granted master.
module dcpu_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic        i_m0_we,
  input  logic [1:0]  i_m0_stb,
  input  logic [31:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic        i_m1_cyc,
  input  logic        i_m1_we,
  input  logic [1:0]  i_m1_stb,
  input  logic [31:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic        o_m0_err,
  output logic        o_m1_err,
  output logic [15:0] o_m_dat,
  output logic        o_cyc,
  output logic        o_we,
  output logic [1:0]  o_stb,
  output logic [31:0] o_addr,
  output logic [15:0] o_dat,
  input  logic        i_ack,
  input  logic [15:0] i_dat,
  output logic [1:0]  o_grant
);

  // Encodings match the one-hot grant so o_grant comes straight from the register.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        gcyc, gwe;
  logic [1:0]  gstb;
  logic [31:0] gaddr;
  logic [15:0] gdat;
  logic        timeout_hit;

  // last = 1 means m1 was served most recently, so m0 wins the tie.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) begin
      return lst ? GRANT0 : GRANT1;
    end else if (r0) begin
      return GRANT0;
    end else if (r1) begin
      return GRANT1;
    end else begin
      return IDLE;
    end
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    gcyc  = 1'b0;
    gwe   = 1'b0;
    gstb  = 2'b00;
    gaddr = 32'd0;
    gdat  = 16'd0;
    case (state)
      GRANT0: begin
        gcyc  = i_m0_cyc;
        gwe   = i_m0_we;
        gstb  = i_m0_stb;
        gaddr = i_m0_addr;
        gdat  = i_m0_dat;
      end
      GRANT1: begin
        gcyc  = i_m1_cyc;
        gwe   = i_m1_we;
        gstb  = i_m1_stb;
        gaddr = i_m1_addr;
        gdat  = i_m1_dat;
      end
      default: begin
        gcyc  = 1'b0;
      end
    endcase
  end

  // An ack arriving on the deadline cycle takes priority over the error.
  assign timeout_hit = gcyc && (gstb != 2'b00) && !i_ack && (cnt == TMO);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arbitrate(i_m0_cyc, i_m1_cyc, last);
      GRANT0:  state_nxt = i_m0_cyc ? GRANT0 : arbitrate(1'b0, i_m1_cyc, last);
      GRANT1:  state_nxt = i_m1_cyc ? GRANT1 : arbitrate(i_m0_cyc, 1'b0, last);
      default: state_nxt = IDLE;
    endcase

    last_nxt = last;
    if (state_nxt == GRANT0 && state != GRANT0) begin
      last_nxt = 1'b0;
    end else if (state_nxt == GRANT1 && state != GRANT1) begin
      last_nxt = 1'b1;
    end else begin
      last_nxt = last;
    end

    // Any clear condition (idle, grant change, ack, no strobe, error) falls to zero.
    cnt_nxt = 16'd0;
    if (state != IDLE && state_nxt == state && gcyc && gstb != 2'b00 && !i_ack && !timeout_hit) begin
      cnt_nxt = cnt + 16'd1;
    end else begin
      cnt_nxt = 16'd0;
    end
  end

  assign o_grant  = state;
  assign o_cyc    = gcyc && !timeout_hit;
  assign o_we     = gwe;
  assign o_stb    = gstb;
  assign o_addr   = gaddr;
  assign o_dat    = gdat;
  assign o_m_dat  = i_dat;
  assign o_m0_ack = (state == GRANT0) && i_m0_cyc && i_ack;
  assign o_m1_ack = (state == GRANT1) && i_m1_cyc && i_ack;
  assign o_m0_err = (state == GRANT0) && timeout_hit;
  assign o_m1_err = (state == GRANT1) && timeout_hit;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Directed scoreboard bench for dcpu_bus_arbiter with TIMEOUT = 4.
module tb_dcpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_we, m1_cyc, m1_we;
  logic [1:0]  m0_stb, m1_stb;
  logic [31:0] m0_addr, m1_addr;
  logic [15:0] m0_dat, m1_dat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0] m_dat;
  logic        cyc, we;
  logic [1:0]  stb;
  logic [31:0] addr;
  logic [15:0] dat;
  logic        ack;
  logic [15:0] sdat;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [1:0]  grant;
    logic        cyc;
    logic [31:0] addr;
    logic [15:0] dat;
    logic        a0, a1, e0, e1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dcpu_bus_arbiter #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(m0_cyc), .i_m0_we(m0_we), .i_m0_stb(m0_stb), .i_m0_addr(m0_addr), .i_m0_dat(m0_dat),
    .i_m1_cyc(m1_cyc), .i_m1_we(m1_we), .i_m1_stb(m1_stb), .i_m1_addr(m1_addr), .i_m1_dat(m1_dat),
    .o_m0_ack(m0_ack), .o_m1_ack(m1_ack), .o_m0_err(m0_err), .o_m1_err(m1_err),
    .o_m_dat(m_dat), .o_cyc(cyc), .o_we(we), .o_stb(stb), .o_addr(addr), .o_dat(dat),
    .i_ack(ack), .i_dat(sdat), .o_grant(grant)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push the expectation, sample mid-cycle, pop and compare, then advance one edge.
  task automatic step(input string tag, input logic [1:0] g, input logic c,
                      input logic [31:0] a, input logic [15:0] d,
                      input logic a0, input logic a1, input logic e0, input logic e1);
    exp_t e;
    e = '{tag: tag, grant: g, cyc: c, addr: a, dat: d, a0: a0, a1: a1, e0: e0, e1: e1};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    cmp({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
    cmp({e.tag, ".cyc"}, 32'(cyc), 32'(e.cyc));
    cmp({e.tag, ".addr"}, addr, e.addr);
    cmp({e.tag, ".dat"}, 32'(dat), 32'(e.dat));
    cmp({e.tag, ".m0_ack"}, 32'(m0_ack), 32'(e.a0));
    cmp({e.tag, ".m1_ack"}, 32'(m1_ack), 32'(e.a1));
    cmp({e.tag, ".m0_err"}, 32'(m0_err), 32'(e.e0));
    cmp({e.tag, ".m1_err"}, 32'(m1_err), 32'(e.e1));
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [15:0] D0 = 16'h1111;
  localparam logic [15:0] D1 = 16'h2222;

  initial begin
    rst = 1'b1; ack = 1'b0; sdat = 16'hBEEF;
    m0_cyc = 1'b0; m0_we = 1'b1; m0_stb = 2'b11; m0_addr = A0; m0_dat = D0;
    m1_cyc = 1'b0; m1_we = 1'b0; m1_stb = 2'b11; m1_addr = A1; m1_dat = D1;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; ack = 1'b1;
    step("idle_ack", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack = 1'b0; m0_cyc = 1'b1;
    step("arb_lat", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("g0_drive", 2'b01, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack = 1'b1;
    step("g0_ack", 2'b01, 1'b1, A0, D0, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b0; m0_cyc = 1'b0;
    step("g0_rel", 2'b01, 1'b0, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle1", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Round-robin after a fresh reset: m0 wins the first tie.
    rst = 1'b1;
    step("rst2", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b1;
    step("tie_lat", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tie_g0", 2'b01, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    m0_cyc = 1'b0;
    step("rel0", 2'b01, 1'b0, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hand_g1", 2'b10, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    m1_cyc = 1'b0;
    step("rel1", 2'b10, 1'b0, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle2", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step("tie2_lat", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tie2_g0", 2'b01, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bus lock: three beats with m1 still requesting.
    ack = 1'b1;
    for (int i = 0; i < 3; i++)
      step("lock_beat", 2'b01, 1'b1, A0, D0, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b0; m0_cyc = 1'b0;
    step("lock_rel", 2'b01, 1'b0, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lock_g1", 2'b10, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    m1_cyc = 1'b0;
    step("rel1b", 2'b10, 1'b0, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle3", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout, restart while cyc held, then ack exactly on the deadline.
    m0_cyc = 1'b1;
    step("to_lat", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("to_wait", 2'b01, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("to_err", 2'b01, 1'b0, A0, D0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("to_restart", 2'b01, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack = 1'b1;
    step("to_ackwins", 2'b01, 1'b1, A0, D0, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b0; m0_cyc = 1'b0;
    step("to_rel", 2'b01, 1'b0, A0, D0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle4", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during GRANT1 with m1 holding cyc.
    m1_cyc = 1'b1;
    step("r_lat", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("r_g1", 2'b10, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("r_assert", 2'b10, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("r_abort", 2'b00, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("r_resume", 2'b10, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    m1_cyc = 1'b0;
    step("r_rel", 2'b10, 1'b0, A1, D1, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    cmp("m_dat", 32'(m_dat), 32'h0000_BEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcpu_bus_arbiter.md
DCPU_BUS_ARBITER -- requirements
Module: dcpu_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255; number of cycles a granted strobe may wait for ack before an error is raised (range 2..65535).
REQ-002 i_clk  in  1  clock; all state changes on the rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_m0_cyc, i_m0_we  in  1 each  master 0 (CPU) cycle request and write enable.
REQ-005 i_m0_stb  in  2  master 0 byte-lane strobes.
REQ-006 i_m0_addr  in  32, i_m0_dat  in  16  master 0 address and write data.
REQ-007 i_m1_cyc, i_m1_we, i_m1_stb[1:0], i_m1_addr[31:0], i_m1_dat[15:0]  in  master 1 (DMA/debug), same meanings.
REQ-008 o_m0_ack, o_m1_ack  out  1 each  per-master acknowledge.
REQ-009 o_m0_err, o_m1_err  out  1 each  per-master timeout error pulse.
REQ-010 o_m_dat  out  16  read data to both masters, equal to i_dat.
REQ-011 o_cyc, o_we  out  1, o_stb  out  2, o_addr  out  32, o_dat  out  16  shared slave bus.
REQ-012 i_ack  in  1, i_dat  in  16  slave acknowledge and read data.
REQ-013 o_grant  out  2  one-hot registered grant (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-014 States: IDLE, GRANT0, GRANT1; o_grant = 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 in IDLE.
REQ-015 Arbitration evaluated in IDLE, and in GRANTx on any cycle where the granted master's cyc is 0 (release).
REQ-016 Arbitration: only one cyc high -> grant that master; both high -> grant the master not served most recently (round-robin); neither -> IDLE.
REQ-017 Grant takes effect on the next rising edge: one-cycle arbitration latency from cyc assertion to bus drive.
REQ-018 While GRANTx and master x cyc = 1, the grant SHALL NOT change regardless of the other master's requests (bus lock for multi-beat transfers).
REQ-019 Handoff on release: if the other master requests in the release cycle, transition directly GRANTx -> GRANTy with no idle cycle.
REQ-020 Slave outputs are a combinational mux of the granted master's cyc/stb/we/addr/dat; in IDLE all slave outputs are 0.
REQ-021 o_mx_ack = i_ack only when master x is granted and its cyc = 1; the non-granted master's ack is always 0.
REQ-022 Last-served flag updates on every transition into GRANT0 (flag=0) or GRANT1 (flag=1).
REQ-023 Timeout counter (16 bit) increments each cycle in GRANTx with granted cyc = 1, stb != 0, i_ack = 0; clears on i_ack, on stb = 0, on grant change, and in IDLE.
REQ-024 Counter reaching TIMEOUT: o_mx_err pulses high for exactly one cycle to the granted master, o_cyc forced 0 that cycle, counter clears.
REQ-025 After an error the grant is retained until the master drops cyc; a master keeping cyc high restarts the timeout count.
REQ-026 i_ack arriving in the same cycle as the counter reaching TIMEOUT: ack wins, no error.
REQ-027 i_ack while IDLE is ignored (no master ack, no state change).

Reset
REQ-028 i_reset SHALL force IDLE, o_grant = 0, counter = 0, last-served = m1 (so m0 wins the first tie), all acks/errs 0, all slave outputs 0.
REQ-029 Reset asserted mid-transfer SHALL abort the grant on the same edge; outputs are 0 in the following cycle regardless of cyc inputs.

Verification
REQ-030 m0_cyc=1, stb=2'b11, addr=0x0000_0010 from IDLE -> cycle 1 o_grant=01, o_addr=0x10; i_ack=1 -> o_m0_ack=1, o_m1_ack=0.
REQ-031 Both cyc rise together after reset -> GRANT0 first; m0 drops cyc while m1 holds -> next edge GRANT1 with no idle cycle; next tie -> GRANT0.
REQ-032 m1 requests while m0 holds a 3-beat transfer (cyc held, 3 acks) -> o_grant stays 01 for all 3 beats, m1 granted the cycle after m0 releases.
REQ-033 TIMEOUT=4, m0 granted, stb=2'b11, no ack -> o_m0_err=1 for exactly one cycle after 4 waiting cycles, o_cyc=0 that cycle, o_grant remains 01.
REQ-034 i_reset pulsed during GRANT1 with m1_cyc held high -> o_grant=00, o_cyc=0 next cycle; arbitration resumes after reset deasserts.
